// File: rtl/isquare_pkg.sv
// isquare_pkg: shared widths and FSM state encoding for the iterative squarer.
//   R_W  - operand width (r_i, iteration counter)
//   SQ_W - result / accumulator width
//   D_W  - odd-term width (max term 2*255+1 = 511)
package isquare_pkg;

  localparam int unsigned R_W  = 8;
  localparam int unsigned SQ_W = 16;
  localparam int unsigned D_W  = 9;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    ACC   = 3'd2,
    DINC  = 3'd3,
    END   = 3'd4
  } isq_state_t;

endpackage

// File: rtl/isquare_ctrl.sv
// isquare_ctrl: sequencing FSM for the iterative squarer.
// Ports:
//   clk_i     - clock, rising edge
//   rst_i     - synchronous active-high reset
//   valid     - request strobe, honoured only in IDLE
//   cnt_zero  - remaining-iteration counter is zero
//   load_o    - capture operand and clear accumulator
//   acc_en_o  - add current odd term into accumulator
//   dinc_en_o - advance odd term and decrement counter
//   res_en_o  - latch accumulator into the result register
//   busy_o    - high in every state except IDLE
//   ready     - one-cycle completion pulse (END state)
module isquare_ctrl
  import isquare_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic valid,
  input  logic cnt_zero,
  output logic load_o,
  output logic acc_en_o,
  output logic dinc_en_o,
  output logic res_en_o,
  output logic busy_o,
  output logic ready
);

  isq_state_t state, state_nx;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = IDLE;
    load_o    = 1'b0;
    acc_en_o  = 1'b0;
    dinc_en_o = 1'b0;
    res_en_o  = 1'b0;
    busy_o    = 1'b0;
    ready     = 1'b0;
    case (state)
      IDLE: begin
        load_o   = valid;
        state_nx = valid ? CHECK : IDLE;
      end
      CHECK: begin
        busy_o = 1'b1;
        if (cnt_zero) begin
          res_en_o = 1'b1;
          state_nx = END;
        end else begin
          state_nx = ACC;
        end
      end
      ACC: begin
        busy_o   = 1'b1;
        acc_en_o = 1'b1;
        state_nx = DINC;
      end
      DINC: begin
        busy_o    = 1'b1;
        dinc_en_o = 1'b1;
        state_nx  = CHECK;
      end
      END: begin
        busy_o   = 1'b1;
        ready    = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/isquare.sv
// isquare: iterative unsigned squarer, r*r computed as the sum of the
// first r odd numbers (1 + 3 + 5 + ...), one add per three cycles.
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - synchronous active-high reset (clears result too)
//   valid  - request strobe, sampled only while idle
//   r_i    - 8-bit unsigned operand, captured on acceptance
//   sq_o   - 16-bit registered result, held until the next completion
//   busy_o - high while an operation is in progress
//   ready  - one-cycle pulse, sq_o valid in the same cycle
module isquare
  import isquare_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid,
  input  logic [R_W-1:0]  r_i,
  output logic [SQ_W-1:0] sq_o,
  output logic            busy_o,
  output logic            ready
);

  logic [R_W-1:0]  cnt;
  logic [SQ_W-1:0] s;
  logic [D_W-1:0]  d;
  logic [SQ_W-1:0] sq_q;

  logic            cnt_zero;
  logic            load, acc_en, dinc_en, res_en;
  logic [SQ_W-1:0] s_sum;
  logic [D_W-1:0]  d_sum;
  logic [R_W-1:0]  cnt_dec;

  // Neither adder can overflow: d <= 511 and s <= 65025 for r <= 255.
  assign s_sum    = s + {{(SQ_W-D_W){1'b0}}, d};
  assign d_sum    = d + D_W'(2);
  assign cnt_dec  = cnt - R_W'(1);
  assign cnt_zero = (cnt == '0);

  isquare_ctrl u_ctrl (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .valid     (valid),
    .cnt_zero  (cnt_zero),
    .load_o    (load),
    .acc_en_o  (acc_en),
    .dinc_en_o (dinc_en),
    .res_en_o  (res_en),
    .busy_o    (busy_o),
    .ready     (ready)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt  <= '0;
      s    <= '0;
      d    <= D_W'(1);
      sq_q <= '0;
    end else begin
      if (load) begin
        cnt <= r_i;
        s   <= '0;
        d   <= D_W'(1);
      end
      if (acc_en) begin
        s <= s_sum;
      end
      if (dinc_en) begin
        d   <= d_sum;
        cnt <= cnt_dec;
      end
      if (res_en) begin
        sq_q <= s;
      end
    end
  end

  assign sq_o = sq_q;

endmodule

// File: tb/tb_isquare.sv
// tb_isquare: randomized and directed bench for isquare against a
// cycle-count/arithmetic model (ready at 3r+2 cycles after acceptance,
// result r*r).
module tb_isquare;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid;
  logic [7:0]  r_i;
  logic [15:0] sq_o;
  logic        busy_o;
  logic        ready;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  isquare dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .valid  (valid),
    .r_i    (r_i),
    .sq_o   (sq_o),
    .busy_o (busy_o),
    .ready  (ready)
  );

  // Behavioural model: expected outputs for the current cycle.
  logic        m_busy  = 1'b0;
  logic        m_ready = 1'b0;
  logic [15:0] m_sq    = '0;
  int          m_left  = 0;
  int          m_res   = 0;
  logic        chk_en  = 1'b0;

  always @(posedge clk_i) begin
    if (rst_i) begin
      m_busy = 1'b0; m_ready = 1'b0; m_sq = '0; m_left = 0;
    end else if (!m_busy) begin
      if (valid) begin
        m_busy  = 1'b1;
        m_left  = 3 * int'(r_i) + 1;
        m_res   = int'(r_i) * int'(r_i);
        m_ready = 1'b0;
      end
    end else if (m_ready) begin
      m_busy  = 1'b0;
      m_ready = 1'b0;
    end else begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_ready = 1'b1;
        m_sq    = 16'(m_res);
      end
    end
  end

  always @(negedge clk_i) begin
    if (chk_en) begin
      total++;
      if (busy_o !== m_busy || ready !== m_ready || sq_o !== m_sq) begin
        bad++;
        $display("FAIL model t=%0t busy=%b/%b ready=%b/%b sq=%0d/%0d (dut/model)",
                 $time, busy_o, m_busy, ready, m_ready, sq_o, m_sq);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Single request in the current cycle (cycle 0); optional extra valid
  // pulse at cycle pulse_at. Returns after the ready cycle.
  task automatic req(input string name, input int r, input int exp_sq,
                     input int exp_cyc, input int pulse_at, input int pulse_r);
    int n;
    valid = 1'b1; r_i = 8'(r);
    @(negedge clk_i);
    n = 1;
    valid = (pulse_at == 1); r_i = (pulse_at == 1) ? 8'(pulse_r) : 8'(r);
    while (!ready && n < 900) begin
      @(negedge clk_i);
      n++;
      valid = (pulse_at == n);
      if (pulse_at == n) r_i = 8'(pulse_r);
    end
    valid = 1'b0;
    check({name, "_cycle"}, n, exp_cyc);
    check({name, "_sq"}, int'(sq_o), exp_sq);
    @(negedge clk_i);
  endtask

  initial begin
    int n;
    logic seen_ready;
    rst_i = 1'b1; valid = 1'b0; r_i = '0;
    @(posedge clk_i);
    @(negedge clk_i);
    chk_en = 1'b1;
    check("reset_sq", int'(sq_o), 0);
    check("reset_busy", int'(busy_o), 0);
    check("reset_ready", int'(ready), 0);
    rst_i = 1'b0;
    @(negedge clk_i);

    req("r0",   0,     0,   2, 0, 0);
    req("r13",  13,  169,  41, 0, 0);
    req("r255", 255, 65025, 767, 0, 0);
    req("r5_ign", 5,  25,  17, 4, 9);

    // Back-to-back with valid held high; operand changes after first accept.
    valid = 1'b1; r_i = 8'd3;
    n = 0;
    seen_ready = 1'b0;
    while (n < 40) begin
      @(negedge clk_i);
      n++;
      if (n == 1) r_i = 8'd4;
      if (n == 13) valid = 1'b0;
      if (ready && n == 11) check("b2b_first", int'(sq_o), 9);
      if (ready && n == 26) begin check("b2b_second", int'(sq_o), 16); seen_ready = 1'b1; end
      if (ready && n != 11 && n != 26) check("b2b_stray_ready", n, 0);
      if (n == 27) n = 40;
    end
    check("b2b_second_seen", int'(seen_ready), 1);

    // Reset aborts an operation in flight.
    valid = 1'b1; r_i = 8'd200;
    seen_ready = 1'b0;
    for (int c = 1; c <= 51; c++) begin
      @(negedge clk_i);
      valid = 1'b0;
      if (ready) seen_ready = 1'b1;
      rst_i = (c == 50);
      if (c == 51) begin
        check("abort_busy", int'(busy_o), 0);
        check("abort_sq", int'(sq_o), 0);
      end
    end
    check("abort_no_ready", int'(seen_ready), 0);
    req("after_abort", 2, 4, 8, 0, 0);

    // Random traffic, model-checked every cycle.
    for (int c = 0; c < 8000; c++) begin
      valid = ($urandom_range(0, 3) == 0);
      r_i   = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(0, 255))
                                           : 8'($urandom_range(0, 30));
      rst_i = ($urandom_range(0, 599) == 0);
      @(negedge clk_i);
    end
    rst_i = 1'b0; valid = 1'b0;
    @(negedge clk_i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
